// File: rtl/debug_unit.sv
// Debug unit: a UART command front end that loads instruction memory, runs or
// single-steps the processor, and streams a 304-bit pipeline snapshot back out
// as 38 bytes, most significant byte first.
module debug_unit #(
  parameter int INST_MEM_DEPTH = 256
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  input  logic         i_tx_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_start,
  output logic         o_we_IF,
  output logic [31:0]  o_instruction_data,
  output logic [31:0]  o_instruction_addr,
  output logic         o_halt,
  input  logic         i_end,
  input  logic [143:0] i_segment_registers_ID_EX,
  input  logic [31:0]  i_segment_registers_EX_MEM,
  input  logic [47:0]  i_segment_registers_MEM_WB,
  input  logic [39:0]  i_segment_registers_WB_ID,
  input  logic [23:0]  i_control_registers_ID_EX,
  input  logic [15:0]  i_pcounterIF2ID_LSB
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * INST_MEM_DEPTH);
  localparam logic [5:0]  LAST_IDX   = 6'd37;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_SNAP = 8'h44;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, STEP, SNAP, SEND, WAIT_BUSY, WAIT_DONE
  } state_t;

  state_t       state, state_next;
  logic [1:0]   byte_cnt;
  logic [23:0]  word_q;
  logic [5:0]   send_idx;
  logic [303:0] snap;

  logic         load_start;
  logic         word_done;
  logic         tx_go;
  logic         send_adv;

  logic [31:0]  assembled;
  logic [31:0]  addr_plus;
  logic [31:0]  addr_inc;
  logic [7:0]   snap_byte;

  // The three earlier bytes sit in word_q; the incoming byte completes the word.
  assign assembled = {word_q, i_rx_data};
  assign addr_plus = o_instruction_addr + 32'd4;
  assign addr_inc  = (addr_plus >= ADDR_LIMIT) ? 32'd0 : addr_plus;
  // Index 0 selects bits [303:296], index 37 selects bits [7:0].
  assign snap_byte = snap[{(LAST_IDX - send_idx), 3'b000} +: 8];

  // The pipeline runs only in RUN and during the single STEP cycle.
  assign o_halt = !((state == RUN) || (state == STEP));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and one-cycle control strobes.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    word_done  = 1'b0;
    tx_go      = 1'b0;
    send_adv   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_next = LOAD;
              load_start = 1'b1;
            end
            CMD_RUN:  state_next = RUN;
            CMD_STEP: state_next = STEP;
            CMD_SNAP: state_next = SNAP;
            default:  state_next = IDLE;
          endcase
        end
      end
      LOAD: begin
        if (i_rx_valid && (byte_cnt == 2'd3)) begin
          word_done = 1'b1;
          // An all-ones word is still written; it just ends the load.
          if (assembled == 32'hFFFF_FFFF) state_next = IDLE;
        end
      end
      RUN:  if (i_end) state_next = SNAP;
      STEP: state_next = SNAP;
      SNAP: state_next = SEND;
      SEND: begin
        if (i_tx_ready) begin
          tx_go      = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (!i_tx_ready) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_ready) begin
          send_adv   = 1'b1;
          state_next = (send_idx == LAST_IDX) ? IDLE : SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Load datapath, snapshot capture and transmit datapath.
  // NOTE: the snapshot is a plain flop vector, not a RAM, so it is cleared by
  // reset along with the rest of the state.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt           <= 2'd0;
      word_q             <= 24'd0;
      send_idx           <= 6'd0;
      snap               <= '0;
      o_we_IF            <= 1'b0;
      o_tx_start         <= 1'b0;
      o_tx_data          <= 8'd0;
      o_instruction_data <= 32'd0;
      o_instruction_addr <= 32'd0;
    end else begin
      o_we_IF    <= word_done;
      o_tx_start <= tx_go;

      // A new load restarts at address 0; otherwise step past the word just written.
      if (load_start) begin
        byte_cnt           <= 2'd0;
        o_instruction_addr <= 32'd0;
      end else if (o_we_IF) begin
        o_instruction_addr <= addr_inc;
      end

      // Bytes shift in MSB first; the 2-bit counter wraps after each word.
      if ((state == LOAD) && i_rx_valid) begin
        word_q   <= assembled[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (word_done) o_instruction_data <= assembled;

      if (state == SNAP) begin
        snap     <= {i_pcounterIF2ID_LSB, i_control_registers_ID_EX,
                     i_segment_registers_WB_ID, i_segment_registers_MEM_WB,
                     i_segment_registers_EX_MEM, i_segment_registers_ID_EX};
        send_idx <= 6'd0;
      end

      if (tx_go)    o_tx_data <= snap_byte;
      if (send_adv) send_idx  <= send_idx + 6'd1;
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: scoreboards for instruction writes and transmitted
// bytes, a UART transmitter model with a fixed busy time, and one task per
// scenario. A second instance with INST_MEM_DEPTH=2 covers address wrap.
module tb_debug_unit;

  localparam int BUSY = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         tx_ready;
  logic         end_in;
  logic [143:0] id_ex;
  logic [31:0]  ex_mem;
  logic [47:0]  mem_wb;
  logic [39:0]  wb_id;
  logic [23:0]  ctrl;
  logic [15:0]  pc;

  logic [7:0]   tx_data;
  logic         tx_start;
  logic         we;
  logic [31:0]  instr_data;
  logic [31:0]  instr_addr;
  logic         halt;

  logic [7:0]   rx_data_w;
  logic         rx_valid_w;
  logic [7:0]   tx_data_w;
  logic         tx_start_w;
  logic         we_w;
  logic [31:0]  instr_data_w;
  logic [31:0]  instr_addr_w;
  logic         halt_w;

  wr_t        wr_q[$];
  wr_t        wr_w_q[$];
  logic [7:0] tx_q[$];

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int n_writes = 0;
  int n_writes_w = 0;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk                        (clk),
    .i_reset                    (i_reset),
    .i_rx_data                  (rx_data),
    .i_rx_valid                 (rx_valid),
    .i_tx_ready                 (tx_ready),
    .o_tx_data                  (tx_data),
    .o_tx_start                 (tx_start),
    .o_we_IF                    (we),
    .o_instruction_data         (instr_data),
    .o_instruction_addr         (instr_addr),
    .o_halt                     (halt),
    .i_end                      (end_in),
    .i_segment_registers_ID_EX  (id_ex),
    .i_segment_registers_EX_MEM (ex_mem),
    .i_segment_registers_MEM_WB (mem_wb),
    .i_segment_registers_WB_ID  (wb_id),
    .i_control_registers_ID_EX  (ctrl),
    .i_pcounterIF2ID_LSB        (pc)
  );

  debug_unit #(.INST_MEM_DEPTH(2)) dut_w (
    .clk                        (clk),
    .i_reset                    (i_reset),
    .i_rx_data                  (rx_data_w),
    .i_rx_valid                 (rx_valid_w),
    .i_tx_ready                 (1'b1),
    .o_tx_data                  (tx_data_w),
    .o_tx_start                 (tx_start_w),
    .o_we_IF                    (we_w),
    .o_instruction_data         (instr_data_w),
    .o_instruction_addr         (instr_addr_w),
    .o_halt                     (halt_w),
    .i_end                      (1'b0),
    .i_segment_registers_ID_EX  (id_ex),
    .i_segment_registers_EX_MEM (ex_mem),
    .i_segment_registers_MEM_WB (mem_wb),
    .i_segment_registers_WB_ID  (wb_id),
    .i_control_registers_ID_EX  (ctrl),
    .i_pcounterIF2ID_LSB        (pc)
  );

  // UART transmitter model: ready drops for BUSY cycles after each start.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_ready = 1'b0;
        repeat (BUSY) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Output monitor for the main instance: pops the scoreboards on each strobe.
  initial begin
    logic prev_we, prev_start;
    wr_t  ew;
    logic [7:0] eb;
    prev_we = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        n_writes++;
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected addr=%h data=%h", instr_addr, instr_data);
        end else begin
          ew = wr_q.pop_front();
          if ({instr_addr, instr_data} !== {ew.addr, ew.data}) begin
            bad++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     instr_addr, instr_data, ew.addr, ew.data);
          end
        end
      end
      if (tx_start === 1'b1) begin
        n_starts++;
        total++;
        if (tx_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected data=%h", tx_data);
        end else begin
          eb = tx_q.pop_front();
          if (tx_data !== eb) begin
            bad++;
            $display("FAIL tx_byte got=%h want=%h", tx_data, eb);
          end
        end
      end
      if ((we === 1'b1) || (tx_start === 1'b1)) begin
        total++;
        if ((we && tx_start) || (we && prev_we) || (tx_start && prev_start)) begin
          bad++;
          $display("FAIL strobe_overlap we=%b start=%b prev_we=%b prev_start=%b want single pulses",
                   we, tx_start, prev_we, prev_start);
        end
      end
      prev_we = we;
      prev_start = tx_start;
    end
  end

  // Output monitor for the wrap instance.
  initial begin
    wr_t ew;
    forever begin
      @(negedge clk);
      if (we_w === 1'b1) begin
        n_writes_w++;
        total++;
        if (wr_w_q.size() == 0) begin
          bad++;
          $display("FAIL wrap_write_unexpected addr=%h data=%h", instr_addr_w, instr_data_w);
        end else begin
          ew = wr_w_q.pop_front();
          if ({instr_addr_w, instr_data_w} !== {ew.addr, ew.data}) begin
            bad++;
            $display("FAIL wrap_write got addr=%h data=%h want addr=%h data=%h",
                     instr_addr_w, instr_data_w, ew.addr, ew.data);
          end
        end
      end
      if (tx_start_w === 1'b1) begin
        total++;
        bad++;
        $display("FAIL wrap_tx_unexpected got start=1 want 0");
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_byte_w(input logic [7:0] b);
    @(negedge clk);
    rx_data_w = b;
    rx_valid_w = 1'b1;
    @(negedge clk);
    rx_valid_w = 1'b0;
    rx_data_w = 8'h00;
  endtask

  task automatic send_word_w(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte_w(w[8*i +: 8]);
  endtask

  task automatic randomize_snap();
    id_ex  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    ex_mem = $urandom();
    mem_wb = {$urandom(), 16'($urandom())};
    wb_id  = {$urandom(), 8'($urandom())};
    ctrl   = 24'($urandom());
    pc     = 16'($urandom());
  endtask

  // Expected byte stream from the current inputs, bits [303:296] first.
  task automatic push_snap();
    logic [303:0] s;
    s = {pc, ctrl, wb_id, mem_wb, ex_mem, id_ex};
    for (int i = 0; i < 38; i++) tx_q.push_back(s[303 - 8*i -: 8]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (((wr_q.size() + tx_q.size() + wr_w_q.size()) != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ((wr_q.size() + tx_q.size() + wr_w_q.size()) != 0) begin
      bad++;
      $display("FAIL %s_timeout got pending wr=%0d tx=%0d wr_w=%0d want 0",
               name, wr_q.size(), tx_q.size(), wr_w_q.size());
      wr_q.delete();
      tx_q.delete();
      wr_w_q.delete();
    end
    repeat (BUSY + 6) @(negedge clk);
  endtask

  task automatic count_halt_low(input int cycles, input int end_at, output int lows);
    lows = 0;
    for (int k = 0; k < cycles; k++) begin
      if (halt === 1'b0) lows++;
      if (k == end_at) end_in = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({halt, we, tx_start, tx_data, instr_data, instr_addr} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_values got halt=%b we=%b start=%b tx=%h data=%h addr=%h want 1 0 0 0 0 0",
               halt, we, tx_start, tx_data, instr_data, instr_addr);
    end
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    int w0;
    w0 = n_writes;
    wr_q.push_back('{addr: 32'h0, data: 32'h2001_0005});
    wr_q.push_back('{addr: 32'h4, data: 32'hFFFF_FFFF});
    send_byte(8'h4C);
    send_byte(8'h20);
    send_byte(8'h01);
    repeat (50) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(32'hFFFF_FFFF);
    wait_drain("load", 200);
    total++;
    if (n_writes - w0 != 2) begin
      bad++;
      $display("FAIL load_count got=%0d want=2", n_writes - w0);
    end
    // Back in IDLE these bytes must not form another word.
    w0 = n_writes;
    send_word(32'h0102_0305);
    repeat (10) @(negedge clk);
    total++;
    if (n_writes != w0) begin
      bad++;
      $display("FAIL load_idle_after_end got writes=%0d want=0", n_writes - w0);
    end
  endtask

  task automatic test_wrap();
    wr_w_q.push_back('{addr: 32'h0, data: 32'hA5A5_0001});
    wr_w_q.push_back('{addr: 32'h4, data: 32'h0BAD_F00D});
    wr_w_q.push_back('{addr: 32'h0, data: 32'hFFFF_FFFF});
    send_byte_w(8'h4C);
    send_word_w(32'hA5A5_0001);
    send_word_w(32'h0BAD_F00D);
    send_word_w(32'hFFFF_FFFF);
    wait_drain("wrap", 200);
    total++;
    if (n_writes_w != 3) begin
      bad++;
      $display("FAIL wrap_count got=%0d want=3", n_writes_w);
    end
  endtask

  task automatic test_run();
    int s0, lows;
    randomize_snap();
    push_snap();
    end_in = 1'b0;
    s0 = n_starts;
    send_byte(8'h43);
    count_halt_low(30, 9, lows);
    randomize_snap();
    total++;
    if (lows != 10) begin
      bad++;
      $display("FAIL run_halt_low got=%0d want=10", lows);
    end
    wait_drain("run", 2000);
    total++;
    if (n_starts - s0 != 38) begin
      bad++;
      $display("FAIL run_starts got=%0d want=38", n_starts - s0);
    end
    end_in = 1'b0;
  endtask

  task automatic test_run_end_high();
    int s0, lows;
    randomize_snap();
    push_snap();
    end_in = 1'b1;
    s0 = n_starts;
    send_byte(8'h43);
    count_halt_low(6, 0, lows);
    randomize_snap();
    end_in = 1'b0;
    total++;
    if (lows != 1) begin
      bad++;
      $display("FAIL run_end_high_halt_low got=%0d want=1", lows);
    end
    wait_drain("run_end_high", 2000);
    total++;
    if (n_starts - s0 != 38) begin
      bad++;
      $display("FAIL run_end_high_starts got=%0d want=38", n_starts - s0);
    end
  endtask

  task automatic test_step();
    int s0, lows;
    randomize_snap();
    push_snap();
    end_in = 1'b0;
    s0 = n_starts;
    send_byte(8'h53);
    count_halt_low(8, 100, lows);
    randomize_snap();
    total++;
    if (lows != 1) begin
      bad++;
      $display("FAIL step_halt_low got=%0d want=1", lows);
    end
    wait_drain("step", 2000);
    total++;
    if (n_starts - s0 != 38) begin
      bad++;
      $display("FAIL step_starts got=%0d want=38", n_starts - s0);
    end
  endtask

  task automatic test_reset_abandon();
    int w0, s0, s_at, n;
    // Reset mid-load: the partial word is dropped.
    w0 = n_writes;
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    #2;
    i_reset = 1'b0;
    #1;
    total++;
    if ({halt, we, tx_start, tx_data, instr_data, instr_addr} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_async got halt=%b we=%b start=%b tx=%h data=%h addr=%h want 1 0 0 0 0 0",
               halt, we, tx_start, tx_data, instr_data, instr_addr);
    end
    @(negedge clk);
    i_reset = 1'b1;
    repeat (20) @(negedge clk);
    randomize_snap();
    push_snap();
    s0 = n_starts;
    send_byte(8'h44);
    wait_drain("reset_snap", 2000);
    total++;
    if ((n_writes != w0) || (n_starts - s0 != 38)) begin
      bad++;
      $display("FAIL reset_load_abandon got writes=%0d starts=%0d want 0 38",
               n_writes - w0, n_starts - s0);
    end

    // Reset mid-send: no further starts until a new command.
    randomize_snap();
    push_snap();
    s0 = n_starts;
    send_byte(8'h44);
    n = 0;
    while ((n_starts - s0 < 3) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n_starts - s0 < 3) begin
      bad++;
      $display("FAIL reset_send_progress got starts=%0d want 3", n_starts - s0);
    end
    #2;
    i_reset = 1'b0;
    tx_q.delete();
    @(negedge clk);
    i_reset = 1'b1;
    s_at = n_starts;
    repeat (100) @(negedge clk);
    total++;
    if (n_starts != s_at) begin
      bad++;
      $display("FAIL reset_send_abandon got starts=%0d want 0", n_starts - s_at);
    end

    // Fresh load after reset starts at byte 0 and address 0.
    wr_q.push_back('{addr: 32'h0, data: 32'hDEAD_BEEF});
    wr_q.push_back('{addr: 32'h4, data: 32'hFFFF_FFFF});
    send_byte(8'h4C);
    send_word(32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    wait_drain("reload", 200);
  endtask

  task automatic test_ignore();
    int w0, s0, highs;
    w0 = n_writes;
    s0 = n_starts;
    highs = 0;
    send_byte(8'h7A);
    for (int k = 0; k < 20; k++) begin
      if (halt === 1'b1) highs++;
      @(negedge clk);
    end
    total++;
    if ((n_writes != w0) || (n_starts != s0) || (highs != 20)) begin
      bad++;
      $display("FAIL ignore_unknown got writes=%0d starts=%0d halt_high=%0d want 0 0 20",
               n_writes - w0, n_starts - s0, highs);
    end
  endtask

  initial begin
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rx_data_w = 8'h00;
    rx_valid_w = 1'b0;
    end_in = 1'b0;
    randomize_snap();
    test_reset();
    test_load();
    test_wrap();
    test_run();
    test_run_end_high();
    test_step();
    test_reset_abandon();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter INST_MEM_DEPTH, default 256: number of 32-bit instruction words; the load address wraps at 4*INST_MEM_DEPTH bytes.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 i_reset  in  1  reset, asynchronous and active-low.
REQ-004 i_rx_data  in  8  received UART byte.
REQ-005 i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
REQ-006 i_tx_ready  in  1  UART transmitter idle; it drops while a byte is being sent.
REQ-007 o_tx_data  out  8  byte to transmit.
REQ-008 o_tx_start  out  1  one-cycle transmit strobe.
REQ-009 o_we_IF  out  1  instruction-memory write strobe to the processor.
REQ-010 o_instruction_data  out  32  instruction word to write.
REQ-011 o_instruction_addr  out  32  byte address to write.
REQ-012 o_halt  out  1  processor halt; 1 freezes the pipeline.
REQ-013 i_end  in  1  processor reached its halt instruction.
REQ-014 i_segment_registers_ID_EX  in  144; i_segment_registers_EX_MEM  in  32; i_segment_registers_MEM_WB  in  48; i_segment_registers_WB_ID  in  40; i_control_registers_ID_EX  in  24; i_pcounterIF2ID_LSB  in  16: debug snapshot sources.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, RUN, STEP, SNAP, SEND, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE, each i_rx_valid byte SHALL be decoded as follows:
- 0x4C -> LOAD
- 0x43 -> RUN
- 0x53 -> STEP
- 0x44 -> SNAP
- any other value -> ignored, stay in IDLE.
REQ-017 On entry to LOAD, the byte counter and o_instruction_addr SHALL clear to 0.
REQ-018 In LOAD, bytes SHALL assemble MSB first into a 32-bit word.
REQ-019 The cycle after the 4th byte's i_rx_valid, the block SHALL:
- set o_instruction_data to the assembled word;
- pulse o_we_IF for exactly 1 cycle.
REQ-020 After each write, o_instruction_addr SHALL advance by 4, modulo 4*INST_MEM_DEPTH.
REQ-021 An assembled word equal to 0xFFFFFFFF SHALL be written like any other word, and the FSM SHALL then return to IDLE.
REQ-022 A partial word SHALL persist across idle gaps of any length; there is no timeout.
REQ-023 o_halt SHALL be 0 only in RUN and during the single STEP cycle; it SHALL be 1 in all other states.
REQ-024 RUN SHALL deassert o_halt until i_end=1 is sampled, then go to SNAP. If i_end is already 1 on entry, RUN SHALL exit after one cycle.
REQ-025 STEP SHALL hold o_halt=0 for exactly 1 clock, then go to SNAP.
REQ-026 SNAP SHALL capture 304 bits {i_pcounterIF2ID_LSB, i_control_registers_ID_EX, i_segment_registers_WB_ID, i_segment_registers_MEM_WB, i_segment_registers_EX_MEM, i_segment_registers_ID_EX} in one cycle, with o_halt=1.
REQ-027 SNAP SHALL clear the 6-bit send index to 0.
REQ-028 Bytes SHALL be sent in 38 transfers, captured bits [303:296] first and [7:0] last; the transmitted data SHALL be the capture, not the live inputs.
REQ-029 SEND SHALL wait for i_tx_ready=1, then drive o_tx_data and a 1-cycle o_tx_start, then go to WAIT_BUSY.
REQ-030 WAIT_BUSY SHALL wait for i_tx_ready=0; WAIT_DONE SHALL then wait for i_tx_ready=1.
REQ-031 After WAIT_DONE, the send index SHALL increment; the FSM SHALL return to SEND if the index is below 38, otherwise to IDLE.
REQ-032 i_rx_valid SHALL be ignored in RUN, STEP, SNAP, SEND, WAIT_BUSY and WAIT_DONE.
REQ-033 o_tx_start and o_we_IF SHALL never be asserted in the same cycle, and neither SHALL assert for 2 consecutive cycles.

Reset
REQ-034 While i_reset=0, regardless of clock, all outputs SHALL take their reset values:
- FSM: IDLE
- o_halt=1
- o_we_IF=0, o_tx_start=0
- o_tx_data=0, o_instruction_data=0, o_instruction_addr=0
- byte counter, send index and snapshot cleared.
REQ-035 A reset mid-LOAD or mid-SEND SHALL abandon the operation; no write or transmit strobe SHALL occur after reset release until a new command arrives.

Verification
REQ-036 Load: send 4C, 20 01 00 05, FF FF FF FF -> two o_we_IF pulses: (addr 0, data 0x20010005) then (addr 4, data 0xFFFFFFFF); FSM returns to IDLE.
REQ-037 Wrap: INST_MEM_DEPTH=2, send 4C and three words (the last 0xFFFFFFFF) -> write addresses 0, 4, 0.
REQ-038 Run: send 43, hold i_end=0 for 10 cycles then raise it -> o_halt=0 for those cycles and 1 after; 38 bytes follow, the first equal to i_pcounterIF2ID_LSB[15:8].
REQ-039 Step and handshake: send 53 -> o_halt low for exactly 1 cycle. Hold i_tx_ready low 5 cycles after each start -> exactly 38 starts, one per ready cycle; inputs changed after SNAP do not alter the sent data.
REQ-040 Reset and ignore: pull i_reset low after the 2nd load byte, release, then send 44 -> 0 writes and 38 bytes sent; an unknown byte 0x7A in IDLE causes no outputs.
